// File: rtl/conv1_frame_ctrl.sv
// conv1 frame sequencer: accepts a raster pixel stream into the window line buffer,
// issues credit-gated window strobes to the conv1 pipeline and tags each result.
module conv1_frame_ctrl #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int K           = 5,
    parameter int CALC_LAT    = 7,
    parameter int OUT_CREDITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    input  logic       i_pix_valid_in,
    output logic       o_pix_ready_out,
    output logic       o_buf_shift_en,
    output logic       o_win_valid,
    input  logic       i_calc_valid_in,
    input  logic       i_credit_return,
    output logic       o_out_valid,
    output logic [4:0] o_out_row,
    output logic [4:0] o_out_col,
    output logic       o_frame_err
);

    localparam int OUT_W     = IMG_W - K + 1;
    localparam int OUT_H     = IMG_H - K + 1;
    localparam int OUT_TOTAL = OUT_W * OUT_H;
    localparam int CLW       = $clog2(IMG_W);
    localparam int RW        = $clog2(IMG_H + 1);
    localparam int CNTW      = $clog2(OUT_TOTAL + 1);
    localparam int CRW       = $clog2(OUT_CREDITS + 1);

    localparam logic [CLW-1:0]  COL_FIRST    = CLW'(K - 1);
    localparam logic [CLW-1:0]  COL_LAST     = CLW'(IMG_W - 1);
    localparam logic [CLW-1:0]  COL_ONE      = CLW'(1);
    localparam logic [RW-1:0]   ROW_FIRST    = RW'(K - 1);
    localparam logic [RW-1:0]   ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [RW-1:0]   ROW_ONE      = RW'(1);
    localparam logic [4:0]      OUT_COL_LAST = 5'(OUT_W - 1);
    localparam logic [4:0]      OUT_ROW_LAST = 5'(OUT_H - 1);
    localparam logic [4:0]      OUT_ONE      = 5'(1);
    localparam logic [CNTW-1:0] CNT_TOTAL    = CNTW'(OUT_TOTAL);
    localparam logic [CNTW-1:0] CNT_LAST     = CNTW'(OUT_TOTAL - 1);
    localparam logic [CNTW-1:0] CNT_ONE      = CNTW'(1);
    localparam logic [CRW-1:0]  CRED_MAX     = CRW'(OUT_CREDITS);
    localparam logic [CRW-1:0]  CRED_ONE     = CRW'(1);

    if (OUT_CREDITS < 1 || CALC_LAT < 1 || OUT_W > 32 || OUT_H > 32) begin : g_badParams
        $error("conv1_frame_ctrl: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [RW-1:0]   r_inRow;
    logic [CLW-1:0]  r_inCol;
    logic [4:0]      r_outRow;
    logic [4:0]      r_outCol;
    logic [CNTW-1:0] r_outCnt;
    logic [CRW-1:0]  r_credits;
    logic            r_winValid;
    logic            r_frameErr;

    logic w_running;
    logic w_active;
    logic w_startFrame;
    logic w_pixReady;
    logic w_accept;
    logic w_winPix;
    logic w_lastPix;
    logic w_resultOk;
    logic w_lastResult;
    logic w_creditOvf;
    logic w_errSet;

    assign w_running    = (r_state == S_RUN);
    assign w_active     = w_running || (r_state == S_DRAIN);
    assign w_startFrame = (r_state == S_IDLE) && i_start;
    assign w_pixReady   = w_running && (r_credits != '0);
    assign w_accept     = i_pix_valid_in && w_pixReady;
    assign w_winPix     = w_accept && (r_inRow >= ROW_FIRST) && (r_inCol >= COL_FIRST);
    assign w_lastPix    = w_accept && (r_inRow == ROW_LAST) && (r_inCol == COL_LAST);
    assign w_resultOk   = i_calc_valid_in && w_active && (r_outCnt < CNT_TOTAL);
    assign w_lastResult = w_resultOk && (r_outCnt == CNT_LAST);
    assign w_creditOvf  = i_credit_return && !w_winPix && (r_credits == CRED_MAX);
    // Any result the frame cannot own (wrong state or past the last index) is a protocol error.
    assign w_errSet     = (i_calc_valid_in && !w_resultOk) || w_creditOvf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (w_lastPix) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_lastResult || (r_outCnt == CNT_TOTAL)) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign o_busy          = w_active;
    assign o_done          = (r_state == S_DONE);
    assign o_pix_ready_out = w_pixReady;
    assign o_buf_shift_en  = w_accept;
    assign o_win_valid     = r_winValid;
    assign o_out_valid     = w_resultOk;
    assign o_out_row       = r_outRow;
    assign o_out_col       = r_outCol;
    assign o_frame_err     = r_frameErr;

    always_ff @(posedge clk) begin
        if (!rst_n || w_startFrame) begin
            r_inRow <= '0;
            r_inCol <= '0;
        end else if (w_accept) begin
            if (r_inCol == COL_LAST) begin
                r_inCol <= '0;
                r_inRow <= r_inRow + ROW_ONE;
            end else begin
                r_inCol <= r_inCol + COL_ONE;
            end
        end
    end

    // The strobe for the final pixel lands in the first DRAIN cycle; no new issue happens there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_winValid <= 1'b0;
        end else begin
            r_winValid <= w_winPix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits <= '0;
        end else if (w_startFrame) begin
            r_credits <= CRED_MAX;
        end else if (w_winPix && !i_credit_return) begin
            r_credits <= r_credits - CRED_ONE;
        end else if (!w_winPix && i_credit_return && (r_credits != CRED_MAX)) begin
            r_credits <= r_credits + CRED_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_startFrame) begin
            r_outRow <= '0;
            r_outCol <= '0;
            r_outCnt <= '0;
        end else if (w_resultOk) begin
            r_outCnt <= r_outCnt + CNT_ONE;
            if (r_outCol == OUT_COL_LAST) begin
                r_outCol <= '0;
                r_outRow <= (r_outRow == OUT_ROW_LAST) ? '0 : r_outRow + OUT_ONE;
            end else begin
                r_outCol <= r_outCol + OUT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frameErr <= 1'b0;
        end else if (w_startFrame) begin
            r_frameErr <= w_errSet;
        end else if (w_errSet) begin
            r_frameErr <= 1'b1;
        end
    end

endmodule
